// File: rtl/controle_pratica_if.sv
// rtl/controle_pratica_if.sv - condition/control bundle between controle_pratica and fluxo_dados
interface controle_pratica_if;
   // datapath conditions
   logic nota_feita;
   logic nota_correta;
   logic fimTF;
   logic fimTempo;
   logic enderecoIgualRodada;
   logic fim_musica;
   logic fimCR;
   // datapath controls
   logic zeraR, registraR;
   logic zeraC, contaC;
   logic zeraCR, contaCR;
   logic zeraTempo, contaTempo;
   logic zeraTF, contaTF;
   logic zeraMetro, contaMetro;
   logic leds_mem, ativa_leds, toca;

   modport master (
      input  nota_feita, nota_correta, fimTF, fimTempo, enderecoIgualRodada, fim_musica, fimCR,
      output zeraR, registraR, zeraC, contaC, zeraCR, contaCR, zeraTempo, contaTempo,
             zeraTF, contaTF, zeraMetro, contaMetro, leds_mem, ativa_leds, toca
   );

   modport slave (
      output nota_feita, nota_correta, fimTF, fimTempo, enderecoIgualRodada, fim_musica, fimCR,
      input  zeraR, registraR, zeraC, contaC, zeraCR, contaCR, zeraTempo, contaTempo,
             zeraTF, contaTF, zeraMetro, contaMetro, leds_mem, ativa_leds, toca
   );
endinterface

// File: rtl/controle_pratica.sv
// rtl/controle_pratica.sv - practice session sequencer for the piano datapath
module controle_pratica #(
   parameter int MAX_ERROS = 3,
   parameter int EW        = $clog2(MAX_ERROS + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                press_enter,
   controle_pratica_if.master  dp,
   output logic                inicia_menu,
   output logic                registra_modo,
   output logic                registra_bpm,
   output logic                registra_tom,
   output logic                registra_musicas,
   output logic [2:0]          menu_sel,
   output logic [EW-1:0]       erros_count,
   output logic                fim_ok,
   output logic                fim_erro,
   output logic                fim_timeout,
   output logic [3:0]          db_estado
);

   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      MENU_MODO      = 4'd1,
      MENU_BPM       = 4'd2,
      MENU_TOM       = 4'd3,
      MENU_MUSICA    = 4'd4,
      PREPARA        = 4'd5,
      MOSTRA         = 4'd6,
      PROXIMA_MOSTRA = 4'd7,
      ESPERA         = 4'd8,
      REPETE         = 4'd9,
      COMPARA        = 4'd10,
      FEEDBACK       = 4'd11,
      PROXIMA_JOGADA = 4'd12,
      FIM_ACERTO     = 4'd13,
      FIM_ERRO       = 4'd14,
      FIM_TIMEOUT    = 4'd15
   } estado_t;

   estado_t estado, prox;
   logic    registra_pend;
   logic    em_menu;
   logic    ultimo_erro;

   assign em_menu     = (estado == MENU_MODO) || (estado == MENU_BPM) ||
                        (estado == MENU_TOM)  || (estado == MENU_MUSICA);
   assign ultimo_erro = (erros_count + EW'(1)) >= EW'(MAX_ERROS);
   assign db_estado   = estado;

   // state register
   always_ff @(posedge clock) begin
      if (reset) estado <= INICIAL;
      else       estado <= prox;
   end

   // remembers a menu confirmation so the matching registra_* fires in the following state's first cycle
   always_ff @(posedge clock) begin
      if (reset) registra_pend <= 1'b0;
      else       registra_pend <= em_menu && press_enter;
   end

   // wrong-note counter: cleared on session start, saturates at MAX_ERROS
   always_ff @(posedge clock) begin
      if (reset)
         erros_count <= '0;
      else if (estado == PREPARA)
         erros_count <= '0;
      else if (estado == COMPARA && !dp.nota_correta && erros_count != EW'(MAX_ERROS))
         erros_count <= erros_count + EW'(1);
   end

   // next-state logic
   always_comb begin
      prox = estado;
      case (estado)
         INICIAL:        prox = MENU_MODO;
         MENU_MODO:      if (press_enter) prox = MENU_BPM;
         MENU_BPM:       if (press_enter) prox = MENU_TOM;
         MENU_TOM:       if (press_enter) prox = MENU_MUSICA;
         MENU_MUSICA:    if (press_enter) prox = PREPARA;
         PREPARA:        prox = MOSTRA;
         MOSTRA:         if (dp.fimTF) prox = PROXIMA_MOSTRA;
         PROXIMA_MOSTRA: prox = dp.enderecoIgualRodada ? ESPERA : MOSTRA;
         ESPERA: begin
            if (dp.nota_feita)    prox = COMPARA;
            else if (dp.fimTempo) prox = FIM_TIMEOUT;
         end
         REPETE:         prox = MOSTRA;
         COMPARA: begin
            if (dp.nota_correta)  prox = FEEDBACK;
            else if (ultimo_erro) prox = FIM_ERRO;
            else                  prox = REPETE;
         end
         FEEDBACK:       if (dp.fimTF) prox = PROXIMA_JOGADA;
         PROXIMA_JOGADA: begin
            if (!dp.enderecoIgualRodada)          prox = ESPERA;
            else if (dp.fim_musica || dp.fimCR)   prox = FIM_ACERTO;
            else                                  prox = MOSTRA;
         end
         FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (press_enter) prox = INICIAL;
         default:        prox = INICIAL;
      endcase
   end

   // output decode from the current state (address comparison picks the counter action in 7 and C)
   always_comb begin
      dp.zeraR = 1'b0;      dp.registraR = 1'b0;
      dp.zeraC = 1'b0;      dp.contaC = 1'b0;
      dp.zeraCR = 1'b0;     dp.contaCR = 1'b0;
      dp.zeraTempo = 1'b0;  dp.contaTempo = 1'b0;
      dp.zeraTF = 1'b0;     dp.contaTF = 1'b0;
      dp.zeraMetro = 1'b0;  dp.contaMetro = 1'b0;
      dp.leds_mem = 1'b0;   dp.ativa_leds = 1'b0;   dp.toca = 1'b0;
      inicia_menu = 1'b0;
      registra_modo = 1'b0; registra_bpm = 1'b0;
      registra_tom = 1'b0;  registra_musicas = 1'b0;
      menu_sel = 3'd0;
      fim_ok = 1'b0;        fim_erro = 1'b0;        fim_timeout = 1'b0;
      case (estado)
         INICIAL: begin
            inicia_menu  = 1'b1;
            dp.zeraR     = 1'b1;
            dp.zeraMetro = 1'b1;
         end
         MENU_MODO:   menu_sel = 3'd0;
         MENU_BPM: begin
            menu_sel      = 3'd1;
            registra_modo = registra_pend;
         end
         MENU_TOM: begin
            menu_sel     = 3'd2;
            registra_bpm = registra_pend;
         end
         MENU_MUSICA: begin
            menu_sel     = 3'd3;
            registra_tom = registra_pend;
         end
         PREPARA: begin
            registra_musicas = registra_pend;
            dp.zeraC = 1'b1;  dp.zeraCR = 1'b1;  dp.zeraTF = 1'b1;
            dp.zeraTempo = 1'b1;  dp.zeraMetro = 1'b1;
         end
         MOSTRA: begin
            dp.leds_mem = 1'b1;  dp.ativa_leds = 1'b1;  dp.toca = 1'b1;
            dp.contaTF  = 1'b1;  dp.contaMetro = 1'b1;
         end
         PROXIMA_MOSTRA: begin
            dp.zeraTF = 1'b1;
            dp.zeraC  = dp.enderecoIgualRodada;
            dp.contaC = !dp.enderecoIgualRodada;
         end
         ESPERA: begin
            dp.registraR = 1'b1;  dp.contaTempo = 1'b1;  dp.contaMetro = 1'b1;
         end
         REPETE: begin
            dp.zeraC = 1'b1;  dp.zeraTF = 1'b1;  dp.zeraTempo = 1'b1;  dp.zeraMetro = 1'b1;
         end
         FEEDBACK: begin
            dp.ativa_leds = 1'b1;  dp.toca = 1'b1;
            dp.contaTF    = 1'b1;  dp.contaMetro = 1'b1;
         end
         PROXIMA_JOGADA: begin
            dp.zeraTF    = 1'b1;
            dp.zeraTempo = 1'b1;
            if (!dp.enderecoIgualRodada) begin
               dp.contaC = 1'b1;
            end else if (!(dp.fim_musica || dp.fimCR)) begin
               dp.contaCR = 1'b1;
               dp.zeraC   = 1'b1;
            end
         end
         FIM_ACERTO: begin
            menu_sel = 3'd4;
            fim_ok   = 1'b1;
         end
         FIM_ERRO: begin
            menu_sel = 3'd4;
            fim_erro = 1'b1;
         end
         FIM_TIMEOUT: begin
            menu_sel    = 3'd4;
            fim_timeout = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_controle_pratica.sv
// tb/tb_controle_pratica.sv - scoreboard bench for controle_pratica
module tb_controle_pratica;

   logic       clock;
   logic       reset;
   logic       press_enter;
   logic       inicia_menu, registra_modo, registra_bpm, registra_tom, registra_musicas;
   logic [2:0] menu_sel;
   logic [1:0] erros_count;
   logic       fim_ok, fim_erro, fim_timeout;
   logic [3:0] db_estado;

   controle_pratica_if dpi ();

   controle_pratica #(.MAX_ERROS(3)) dut (
      .clock            (clock),
      .reset            (reset),
      .press_enter      (press_enter),
      .dp               (dpi),
      .inicia_menu      (inicia_menu),
      .registra_modo    (registra_modo),
      .registra_bpm     (registra_bpm),
      .registra_tom     (registra_tom),
      .registra_musicas (registra_musicas),
      .menu_sel         (menu_sel),
      .erros_count      (erros_count),
      .fim_ok           (fim_ok),
      .fim_erro         (fim_erro),
      .fim_timeout      (fim_timeout),
      .db_estado        (db_estado)
   );

   typedef struct packed {
      logic zeraR, registraR, zeraC, contaC, zeraCR, contaCR;
      logic zeraTempo, contaTempo, zeraTF, contaTF, zeraMetro, contaMetro;
      logic leds_mem, ativa_leds, toca, inicia_menu;
      logic registra_modo, registra_bpm, registra_tom, registra_musicas;
      logic fim_ok, fim_erro, fim_timeout;
      logic [2:0] menu_sel;
   } outs_t;

   typedef struct packed {
      int         tag;
      logic [3:0] st;
      logic [1:0] err;
      outs_t      o;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   step_n = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // expected outputs for one cycle, written straight from the state table
   function automatic outs_t model(input int st, input logic eir, input logic fm,
                                   input logic fcr, input bit regp);
      outs_t o;
      o = '0;
      case (st)
         0:  begin o.inicia_menu = 1; o.zeraR = 1; o.zeraMetro = 1; end
         1:  o.menu_sel = 3'd0;
         2:  begin o.menu_sel = 3'd1; o.registra_modo = regp; end
         3:  begin o.menu_sel = 3'd2; o.registra_bpm = regp; end
         4:  begin o.menu_sel = 3'd3; o.registra_tom = regp; end
         5:  begin
                o.registra_musicas = regp;
                o.zeraC = 1; o.zeraCR = 1; o.zeraTF = 1; o.zeraTempo = 1; o.zeraMetro = 1;
             end
         6:  begin
                o.leds_mem = 1; o.ativa_leds = 1; o.toca = 1; o.contaTF = 1; o.contaMetro = 1;
             end
         7:  begin
                o.zeraTF = 1;
                if (eir) o.zeraC = 1; else o.contaC = 1;
             end
         8:  begin o.registraR = 1; o.contaTempo = 1; o.contaMetro = 1; end
         9:  begin o.zeraC = 1; o.zeraTF = 1; o.zeraTempo = 1; o.zeraMetro = 1; end
         10: ;
         11: begin o.ativa_leds = 1; o.toca = 1; o.contaTF = 1; o.contaMetro = 1; end
         12: begin
                o.zeraTF = 1; o.zeraTempo = 1;
                if (!eir) o.contaC = 1;
                else if (!(fm || fcr)) begin o.contaCR = 1; o.zeraC = 1; end
             end
         13: begin o.menu_sel = 3'd4; o.fim_ok = 1; end
         14: begin o.menu_sel = 3'd4; o.fim_erro = 1; end
         15: begin o.menu_sel = 3'd4; o.fim_timeout = 1; end
         default: ;
      endcase
      return o;
   endfunction

   // one clock cycle: record what the DUT must show now, then advance
   task automatic cyc(input int st, input int err, input bit regp);
      exp_t e;
      step_n++;
      e.tag = step_n;
      e.st  = 4'(st);
      e.err = 2'(err);
      e.o   = model(st, dpi.enderecoIgualRodada, dpi.fim_musica, dpi.fimCR, regp);
      sb.push_back(e);
      @(posedge clock); #1;
      press_enter    = 1'b0;
      dpi.nota_feita = 1'b0;
      dpi.fimTF      = 1'b0;
      dpi.fimTempo   = 1'b0;
      reset          = 1'b0;
   endtask

   // state 0 then the four menu pages, pressing enter on the last of gap cycles per page
   task automatic menu(input int err, input int gap);
      cyc(0, err, 0);
      for (int m = 1; m <= 4; m++) begin
         for (int k = 0; k < gap; k++) begin
            if (k == gap - 1) press_enter = 1'b1;
            cyc(m, err, (k == 0) && (m > 1));
         end
      end
      cyc(5, err, 1);
   endtask

   // monitor: compare every cycle that has a pending expectation
   always @(negedge clock) begin
      exp_t  e;
      outs_t a;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = '{dpi.zeraR, dpi.registraR, dpi.zeraC, dpi.contaC, dpi.zeraCR, dpi.contaCR,
               dpi.zeraTempo, dpi.contaTempo, dpi.zeraTF, dpi.contaTF, dpi.zeraMetro, dpi.contaMetro,
               dpi.leds_mem, dpi.ativa_leds, dpi.toca, inicia_menu,
               registra_modo, registra_bpm, registra_tom, registra_musicas,
               fim_ok, fim_erro, fim_timeout, menu_sel};
         checks = checks + 3;
         if (db_estado !== e.st) begin
            errors++;
            $display("FAIL state step %0d: got %0d expected %0d", e.tag, db_estado, e.st);
         end
         if (erros_count !== e.err) begin
            errors++;
            $display("FAIL erros_count step %0d: got %0d expected %0d", e.tag, erros_count, e.err);
         end
         if (a !== e.o) begin
            errors++;
            $display("FAIL outputs step %0d (state %0d): got %h expected %h", e.tag, e.st, a, e.o);
         end
      end
   end

   initial begin
      reset = 1'b1;
      press_enter = 1'b0;
      dpi.nota_feita = 1'b0;  dpi.nota_correta = 1'b0;
      dpi.fimTF = 1'b0;       dpi.fimTempo = 1'b0;
      dpi.enderecoIgualRodada = 1'b0;
      dpi.fim_musica = 1'b0;  dpi.fimCR = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // menu walk with presses 5 cycles apart
      menu(0, 5);

      // round 0 played correctly: 6,7,8,A,B,C,6 with contaCR in C
      dpi.enderecoIgualRodada = 1'b1;  dpi.nota_correta = 1'b1;
      dpi.fimTF = 1'b1;      cyc(6, 0, 0);
      cyc(7, 0, 0);
      dpi.nota_feita = 1'b1; cyc(8, 0, 0);
      cyc(10, 0, 0);
      dpi.fimTF = 1'b1;      cyc(11, 0, 0);
      cyc(12, 0, 0);

      // three wrong notes; enter in state 6 is ignored
      dpi.nota_correta = 1'b0;
      press_enter = 1'b1;    cyc(6, 0, 0);
      for (int n = 0; n < 3; n++) begin
         dpi.fimTF = 1'b1;      cyc(6, n, 0);
         cyc(7, n, 0);
         dpi.nota_feita = 1'b1; cyc(8, n, 0);
         cyc(10, n, 0);
         if (n < 2) cyc(9, n + 1, 0);
      end
      cyc(14, 3, 0);
      press_enter = 1'b1;    cyc(14, 3, 0);

      // timeout session; erros_count survives until state 5
      menu(3, 1);
      dpi.fimTF = 1'b1;      cyc(6, 0, 0);
      cyc(7, 0, 0);
      dpi.fimTempo = 1'b1;   cyc(8, 0, 0);
      cyc(15, 0, 0);
      press_enter = 1'b1;    cyc(15, 0, 0);

      // nota_feita wins over fimTempo; song end via fim_musica
      menu(0, 1);
      dpi.nota_correta = 1'b1;
      dpi.fimTF = 1'b1;      cyc(6, 0, 0);
      cyc(7, 0, 0);
      dpi.nota_feita = 1'b1; dpi.fimTempo = 1'b1; cyc(8, 0, 0);
      cyc(10, 0, 0);
      dpi.fimTF = 1'b1;      cyc(11, 0, 0);
      dpi.fim_musica = 1'b1; cyc(12, 0, 0);
      dpi.fim_musica = 1'b0;
      cyc(13, 0, 0);
      press_enter = 1'b1;    cyc(13, 0, 0);

      // address-mismatch paths, then song end via fimCR
      menu(0, 1);
      dpi.enderecoIgualRodada = 1'b0;
      dpi.fimTF = 1'b1;      cyc(6, 0, 0);
      cyc(7, 0, 0);
      dpi.enderecoIgualRodada = 1'b1;
      dpi.fimTF = 1'b1;      cyc(6, 0, 0);
      cyc(7, 0, 0);
      dpi.nota_feita = 1'b1; cyc(8, 0, 0);
      cyc(10, 0, 0);
      dpi.fimTF = 1'b1;      cyc(11, 0, 0);
      dpi.enderecoIgualRodada = 1'b0;
      cyc(12, 0, 0);
      dpi.enderecoIgualRodada = 1'b1;
      dpi.nota_feita = 1'b1; cyc(8, 0, 0);
      cyc(10, 0, 0);
      dpi.fimTF = 1'b1;      cyc(11, 0, 0);
      dpi.fimCR = 1'b1;      cyc(12, 0, 0);
      dpi.fimCR = 1'b0;
      press_enter = 1'b1;    cyc(13, 0, 0);

      // one mistake, then reset while in feedback
      menu(0, 1);
      dpi.nota_correta = 1'b0;
      dpi.fimTF = 1'b1;      cyc(6, 0, 0);
      cyc(7, 0, 0);
      dpi.nota_feita = 1'b1; cyc(8, 0, 0);
      cyc(10, 0, 0);
      cyc(9, 1, 0);
      dpi.nota_correta = 1'b1;
      dpi.fimTF = 1'b1;      cyc(6, 1, 0);
      cyc(7, 1, 0);
      dpi.nota_feita = 1'b1; cyc(8, 1, 0);
      cyc(10, 1, 0);
      reset = 1'b1;          cyc(11, 1, 0);
      cyc(0, 0, 0);
      cyc(1, 0, 0);

      // let the monitor drain, bounded
      for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clock);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
